range_sort_merge_ctrl: RTL and testbench
========================================

Name: range_sort_merge_ctrl

Overview:
Sequencer that owns the single-port range BRAM (1-cycle read latency, paired low/high 64-bit words) once range loading has finished.
On `start` it bubble-sorts the first `rangeCount` entries in place by `low`, then walks them once to merge overlapping inclusive ranges.
It accumulates the number of distinct IDs covered (Day 5 Part 2 answer).
It replaces ad-hoc loader sequencing as the post-load phase and drives the same BRAM port set as the fresh-filter controller; an external mux selects which one owns the port.

Parameters:
- ADDR_W, 12, BRAM address width; capacity DEPTH = 2**ADDR_W entries
- DATA_W, 64, width of low/high bounds and of totalCount

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin; sampled only in IDLE
- rangeCount  in  ADDR_W+1  number of valid entries at addresses 0..rangeCount-1; sampled with start
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse when totalCount is final
- countValid  out  1  high from done until next accepted start or rst
- totalCount  out  DATA_W  union size of all ranges, mod 2**DATA_W
- bramWE  out  1  BRAM write enable
- bramAddress  out  ADDR_W  BRAM address
- bramLowWData  out  DATA_W  write data, low bound
- bramHighWData  out  DATA_W  write data, high bound
- bramLowRData  in  DATA_W  read data, low bound; valid 1 cycle after address
- bramHighRData  in  DATA_W  read data, high bound; valid 1 cycle after address

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (rst). Everything below is at posedge clk.
- Reset values:
  - state = IDLE; busy, done, countValid, bramWE all 0
  - bramAddress = 0, write data = 0, totalCount = 0
- Reset mid-operation aborts to IDLE. BRAM contents may be left partially sorted; this is not an error.
- `start` is ignored while busy.
- If rangeCount > DEPTH it is clamped to DEPTH.
- Entries are inclusive [low, high] with low <= high. Entries violating this are undefined input.
- Sort phase, skipped when N < 2:
  - Variable `limit` starts at N-1. Each pass walks j = 0..limit-1.
  - SRD_A: address = j.
  - SRD_B: address = j+1; capture entry A from read data.
  - SCMP: capture entry B. If A.low > B.low, go to SWR_A; else j++ (or end pass).
  - SWR_A: we = 1, address = j, data = B.
  - SWR_B: we = 1, address = j+1, data = A; set `swapped`.
  - End of pass: limit--. If swapped == 0 or limit == 0, enter merge; otherwise clear swapped and start the next pass at j = 0.
  - Ties (equal low) are not swapped.
  - Cost: 3 cycles per compare, plus 2 per swap.
- Merge phase, skipped when N = 0:
  - MISS: address = k.
  - MUSE: use read data (l, h).
    - k = 0: cur = (l, h).
    - Else if l <= curH: curH = max(curH, h).
    - Else: acc += curH - curL + 1, then cur = (l, h).
  - k++; return to MISS while k < N.
  - Cost: 2 cycles per entry.
  - Overlap test is l <= curH; never form curH+1, to avoid wrap at all-ones.
  - Adjacent but non-overlapping ranges count identically either way.
- FINISH:
  - totalCount = acc + (curH - curL + 1) when N > 0, else 0.
  - done = 1 and countValid = 1 on the same cycle totalCount is updated; busy drops that cycle.
  - Return to IDLE.
- IDLE: bramWE = 0 at all times. bramWE is only ever high in SWR_A/SWR_B.
- Sums wrap mod 2**DATA_W; there is no overflow flag.
- Accepting a new start clears countValid the next cycle. totalCount holds its old value until the next FINISH.

Decomposition:
- Shared package range_pkg holds:
  - typedef range_t {low, high} (DATA_W each)
  - ADDR_W and DATA_W defaults
  - state enum: IDLE, SRD_A, SRD_B, SCMP, SWR_A, SWR_B, MISS, MUSE, FINISH
- One sub-module is natural: range_merge_acc. It is purely the merge/accumulate datapath (cur register, overlap compare, size add), reusable by a streaming variant.
- FSM and BRAM port muxing stay in the top.

Test Plan:
- Unsorted example: BRAM = {3-5, 10-14, 16-20, 12-18}, N=4 → BRAM ends sorted {3-5, 10-14, 12-18, 16-20}; totalCount=14; one done pulse; countValid stays high.
- Already sorted: {1-1, 2-2, 3-3}, N=3 → no SWR cycles observed (single pass, early exit); totalCount=3.
- Boundaries: N=0 → no BRAM reads, totalCount=0, done within 2 cycles of start. N=1 with {0, 2**64-1} → totalCount=0 (wrap), no overflow X.
- Contained/duplicate ranges: {5-100, 10-20, 10-20, 100-100}, N=4 → totalCount=96.
- start while busy is ignored; rst asserted mid-sort → busy/done/bramWE=0 next cycle. A fresh start after reload of {3-5} → totalCount=3.
- rangeCount=4097 with DEPTH=4096 → clamped; bramAddress never exceeds 4095.

Source files
------------

// File: rtl/range_pkg.sv
// Shared types for the range sort/merge sequencer: the paired-bound BRAM
// entry, default widths and the controller state encoding.
package range_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 64;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] low;
        logic [DATA_W_DEF-1:0] high;
    } range_t;

    typedef enum logic [3:0] {
        IDLE,
        SRD_A,
        SRD_B,
        SCMP,
        SWR_A,
        SWR_B,
        MISS,
        MUSE,
        FINISH
    } state_e;

endpackage

// File: rtl/range_merge_acc.sv
// Merge/accumulate datapath: folds a low-sorted stream of inclusive ranges
// into a running union size. total_o is valid once the last entry is used.
module range_merge_acc
    import range_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              use_i,
    input  logic              first_i,
    input  logic [DATA_W-1:0] low_i,
    input  logic [DATA_W-1:0] high_i,
    output logic [DATA_W-1:0] total_o
);

    logic [DATA_W-1:0] cur_low_q;
    logic [DATA_W-1:0] cur_high_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] cur_size;
    logic              overlap;

    // Overlap is tested as low <= curH so that curH+1 never wraps at all-ones.
    always_comb begin
        overlap  = low_i <= cur_high_q;
        cur_size = cur_high_q - cur_low_q + 1'b1;
        total_o  = acc_q + cur_size;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_low_q  <= '0;
            cur_high_q <= '0;
            acc_q      <= '0;
        end else if (use_i) begin
            if (first_i) begin
                cur_low_q  <= low_i;
                cur_high_q <= high_i;
                acc_q      <= '0;
            end else if (overlap) begin
                if (high_i > cur_high_q) begin
                    cur_high_q <= high_i;
                end
            end else begin
                acc_q      <= acc_q + cur_size;
                cur_low_q  <= low_i;
                cur_high_q <= high_i;
            end
        end
    end

endmodule

// File: rtl/range_sort_merge_ctrl.sv
// Post-load sequencer: bubble-sorts the range BRAM in place by low bound,
// then walks it once to compute the size of the union of all ranges.
module range_sort_merge_ctrl
    import range_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   rangeCount,
    output logic              busy,
    output logic              done,
    output logic              countValid,
    output logic [DATA_W-1:0] totalCount,
    output logic              bramWE,
    output logic [ADDR_W-1:0] bramAddress,
    output logic [DATA_W-1:0] bramLowWData,
    output logic [DATA_W-1:0] bramHighWData,
    input  logic [DATA_W-1:0] bramLowRData,
    input  logic [DATA_W-1:0] bramHighRData
);

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   limit_q;
    logic [ADDR_W:0]   k_q;
    logic [ADDR_W-1:0] j_q;
    logic              swapped_q;
    range_t            a_q;
    range_t            rd;

    logic              busy_q;
    logic              done_q;
    logic              cv_q;
    logic [DATA_W-1:0] total_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wlo_q;
    logic [DATA_W-1:0] whi_q;

    logic [ADDR_W:0]   n_clamp;
    logic [ADDR_W:0]   limit_dec;
    logic [ADDR_W:0]   k_inc;
    logic [ADDR_W-1:0] j_inc;
    logic              pass_more;
    logic              sort_done;
    logic              do_swap;
    logic              advance;
    logic [DATA_W-1:0] acc_total;

    assign rd = '{low: bramLowRData, high: bramHighRData};

    always_comb begin
        n_clamp   = (rangeCount > DEPTH_C) ? DEPTH_C : rangeCount;
        limit_dec = limit_q - 1'b1;
        k_inc     = k_q + 1'b1;
        j_inc     = j_q + 1'b1;
        pass_more = ({1'b0, j_q} + 1'b1) < limit_q;
        sort_done = !swapped_q || (limit_dec == '0);
        do_swap   = (state_q == SCMP) && (a_q.low > rd.low);
        advance   = ((state_q == SCMP) && !do_swap) || (state_q == SWR_B);
    end

    range_merge_acc #(
        .DATA_W (DATA_W)
    ) u_merge (
        .clk     (clk),
        .rst     (rst),
        .use_i   (state_q == MUSE),
        .first_i (k_q == '0),
        .low_i   (bramLowRData),
        .high_i  (bramHighRData),
        .total_o (acc_total)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            limit_q   <= '0;
            k_q       <= '0;
            j_q       <= '0;
            swapped_q <= 1'b0;
            a_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cv_q      <= 1'b0;
            total_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wlo_q     <= '0;
            whi_q     <= '0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_q       <= n_clamp;
                        limit_q   <= n_clamp - 1'b1;
                        busy_q    <= 1'b1;
                        cv_q      <= 1'b0;
                        addr_q    <= '0;
                        j_q       <= '0;
                        k_q       <= '0;
                        swapped_q <= 1'b0;
                        if (n_clamp == '0) begin
                            state_q <= FINISH;
                        end else if (n_clamp[ADDR_W:1] == '0) begin
                            state_q <= MISS;
                        end else begin
                            state_q <= SRD_A;
                        end
                    end
                end
                SRD_A: begin
                    addr_q  <= j_inc;
                    state_q <= SRD_B;
                end
                SRD_B: begin
                    a_q     <= rd;
                    state_q <= SCMP;
                end
                SCMP: begin
                    // Entry B is consumed straight from read data as the first write.
                    if (do_swap) begin
                        we_q    <= 1'b1;
                        addr_q  <= j_q;
                        wlo_q   <= rd.low;
                        whi_q   <= rd.high;
                        state_q <= SWR_A;
                    end
                end
                SWR_A: begin
                    we_q      <= 1'b1;
                    addr_q    <= j_inc;
                    wlo_q     <= a_q.low;
                    whi_q     <= a_q.high;
                    swapped_q <= 1'b1;
                    state_q   <= SWR_B;
                end
                SWR_B: begin
                    state_q <= SWR_B;
                end
                MISS: begin
                    state_q <= MUSE;
                end
                MUSE: begin
                    k_q <= k_inc;
                    if (k_inc < n_q) begin
                        addr_q  <= k_inc[ADDR_W-1:0];
                        state_q <= MISS;
                    end else begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    total_q <= (n_q == '0) ? '0 : acc_total;
                    done_q  <= 1'b1;
                    cv_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Shared end-of-compare step for both the no-swap and post-swap paths.
            if (advance) begin
                if (pass_more) begin
                    j_q     <= j_inc;
                    addr_q  <= j_inc;
                    state_q <= SRD_A;
                end else if (sort_done) begin
                    addr_q  <= '0;
                    state_q <= MISS;
                end else begin
                    j_q       <= '0;
                    addr_q    <= '0;
                    limit_q   <= limit_dec;
                    swapped_q <= 1'b0;
                    state_q   <= SRD_A;
                end
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign countValid    = cv_q;
    assign totalCount    = total_q;
    assign bramWE        = we_q;
    assign bramAddress   = addr_q;
    assign bramLowWData  = wlo_q;
    assign bramHighWData = whi_q;

endmodule

// File: tb/tb_range_sort_merge_ctrl.sv
// Scoreboard bench for range_sort_merge_ctrl with a 1-cycle-latency BRAM model.
module tb_range_sort_merge_ctrl;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 64;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW:0]   rangeCount;
    logic          busy;
    logic          done;
    logic          countValid;
    logic [DW-1:0] totalCount;
    logic          bramWE;
    logic [AW-1:0] bramAddress;
    logic [DW-1:0] bramLowWData;
    logic [DW-1:0] bramHighWData;
    logic [DW-1:0] bramLowRData;
    logic [DW-1:0] bramHighRData;

    range_sort_merge_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .rangeCount    (rangeCount),
        .busy          (busy),
        .done          (done),
        .countValid    (countValid),
        .totalCount    (totalCount),
        .bramWE        (bramWE),
        .bramAddress   (bramAddress),
        .bramLowWData  (bramLowWData),
        .bramHighWData (bramHighWData),
        .bramLowRData  (bramLowRData),
        .bramHighRData (bramHighRData)
    );

    logic [DW-1:0] mlo [0:4095];
    logic [DW-1:0] mhi [0:4095];
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_lo;
    logic [DW-1:0] ld_hi;

    always @(posedge clk) begin
        if (bramWE) begin
            mlo[bramAddress] <= bramLowWData;
            mhi[bramAddress] <= bramHighWData;
        end else if (ld_we) begin
            mlo[ld_addr] <= ld_lo;
            mhi[ld_addr] <= ld_hi;
        end
        bramLowRData  <= mlo[bramAddress];
        bramHighRData <= mhi[bramAddress];
    end

    int            total;
    int            bad;
    int            we_cnt;
    int            done_cnt;
    logic [DW-1:0] sb [$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input int unsigned i, input logic [DW-1:0] l, input logic [DW-1:0] h);
        ld_we   = 1'b1;
        ld_addr = i[AW-1:0];
        ld_lo   = l;
        ld_hi   = h;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic kick(input logic [AW:0] n, input logic [DW-1:0] exp, input bit push);
        if (push) sb.push_back(exp);
        start      = 1'b1;
        rangeCount = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget, output int unsigned lat);
        lat = 0;
        while (!done && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Monitor: pops the scoreboard on every done pulse.
    initial begin
        logic [DW-1:0] exp;
        forever begin
            @(negedge clk);
            if (bramWE) we_cnt++;
            if (!rst && done) begin
                done_cnt++;
                chk("sb_nonempty", {63'd0, sb.size() > 0}, 64'd1);
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    chk("totalCount", totalCount, exp);
                end
                chk("cv_at_done", {63'd0, countValid}, 64'd1);
                chk("busy_at_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    initial begin
        int unsigned   lat;
        int            we0;
        int            d0;
        logic [DW-1:0] exp_lo [4];
        logic [DW-1:0] exp_hi [4];

        total = 0; bad = 0; we_cnt = 0; done_cnt = 0;
        rst = 1'b1; start = 1'b0; rangeCount = '0;
        ld_we = 1'b0; ld_addr = '0; ld_lo = '0; ld_hi = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_cv", {63'd0, countValid}, 64'd0);
        chk("rst_we", {63'd0, bramWE}, 64'd0);
        chk("rst_addr", {52'd0, bramAddress}, 64'd0);
        chk("rst_wlo", bramLowWData, 64'd0);
        chk("rst_whi", bramHighWData, 64'd0);
        chk("rst_total", totalCount, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsorted example plus an ignored start while busy.
        load(0, 3, 5); load(1, 10, 14); load(2, 16, 20); load(3, 12, 18);
        we0 = we_cnt; d0 = done_cnt;
        kick(4, 64'd14, 1'b1);
        repeat (3) @(negedge clk);
        chk("busy_mid", {63'd0, busy}, 64'd1);
        start = 1'b1; rangeCount = 13'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, lat);
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt - d0, 64'd1);
        chk("cv_hold", {63'd0, countValid}, 64'd1);
        chk("we_cycles_t1", we_cnt - we0, 64'd2);
        exp_lo = '{3, 10, 12, 16};
        exp_hi = '{5, 14, 18, 20};
        for (int unsigned i = 0; i < 4; i++) begin
            chk($sformatf("sorted_lo%0d", i), mlo[i], exp_lo[i]);
            chk($sformatf("sorted_hi%0d", i), mhi[i], exp_hi[i]);
        end

        // Already sorted: single pass, no writes.
        load(0, 1, 1); load(1, 2, 2); load(2, 3, 3);
        we0 = we_cnt;
        kick(3, 64'd3, 1'b1);
        chk("cv_cleared", {63'd0, countValid}, 64'd0);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        wait_done(200, lat);
        @(negedge clk);
        chk("we_cycles_sorted", we_cnt - we0, 64'd0);

        // N = 0.
        we0 = we_cnt;
        kick(0, 64'd0, 1'b1);
        wait_done(10, lat);
        chk("n0_latency", {63'd0, lat <= 2}, 64'd1);
        @(negedge clk);
        chk("we_cycles_n0", we_cnt - we0, 64'd0);

        // N = 1 full-range: size wraps to 0.
        load(0, 64'd0, '1);
        kick(1, 64'd0, 1'b1);
        wait_done(50, lat);
        @(negedge clk);

        // Contained and duplicate ranges.
        load(0, 5, 100); load(1, 10, 20); load(2, 10, 20); load(3, 100, 100);
        we0 = we_cnt;
        kick(4, 64'd96, 1'b1);
        wait_done(200, lat);
        @(negedge clk);
        chk("we_cycles_ties", we_cnt - we0, 64'd0);

        // Reset mid-sort, then a fresh run.
        load(0, 3, 5); load(1, 10, 14); load(2, 16, 20); load(3, 12, 18);
        kick(4, 64'd0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_we", {63'd0, bramWE}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        load(0, 3, 5);
        kick(1, 64'd3, 1'b1);
        wait_done(50, lat);
        @(negedge clk);

        // rangeCount beyond capacity is clamped to 4096 entries.
        for (int unsigned i = 0; i < 4096; i++) begin
            load(i, 64'(2 * i), 64'(2 * i));
        end
        we0 = we_cnt;
        kick(13'd4097, 64'd4096, 1'b1);
        wait_done(30000, lat);
        @(negedge clk);
        chk("we_cycles_clamp", we_cnt - we0, 64'd0);

        chk("sb_drained", sb.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
